// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_uart_pkg : shared state encoding and frame-length constants. Rev 1.0
// ----------------------------------------------------------------------------
package fifo_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_uart_tx_if : pop handshake between the transmitter and the byte FIFO. Rev 1.0
// ----------------------------------------------------------------------------
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic                 fifo_rd;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;

  modport master (output fifo_rd, input fifo_empty, input fifo_rd_data);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_rd_data);

endinterface
`default_nettype wire

// File: rtl/fifo_uart_baud_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_uart_baud_cnt : bit-time counter, 0..CLKS_PER_BIT-1, clear and terminal count. Rev 1.0
// ----------------------------------------------------------------------------
module fifo_uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count;

  assign tc = (count == CNT_W'(CLKS_PER_BIT - 1));

  // Returning to zero on terminal count keeps the count inside 0..CLKS_PER_BIT-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_uart_tx : FIFO-fed 8N1 UART transmitter with optional even parity. Rev 1.0
// ----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  tx_state_e            state, state_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic                 parity, parity_next;
  logic                 tx_next;
  logic                 bit_tc;
  logic                 pop;

  fifo_uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .tc    (bit_tc)
  );

  // Gated by reset so no pop can be requested while reset is held low
  assign pop          = reset && (state == IDLE) && tx_en && !fifo.fifo_empty;
  assign fifo.fifo_rd = pop;
  assign busy         = pop || (state != IDLE);
  assign frame_done   = (state == STOP) && bit_tc && (bit_idx == 3'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      parity  <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      parity  <= parity_next;
      tx      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    parity_next  = parity;
    tx_next      = 1'b1;

    case (state)
      IDLE: begin
        if (pop) begin
          state_next   = START;
          shreg_next   = fifo.fifo_rd_data;
          parity_next  = ^fifo.fifo_rd_data;
          bit_idx_next = '0;
        end
      end
      START: begin
        if (bit_tc) state_next = DATA;
      end
      DATA: begin
        if (bit_tc) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            bit_idx_next = '0;
            state_next   = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shreg_next   = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_tc) state_next = STOP;
      end
      STOP: begin
        if (bit_tc) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            bit_idx_next = '0;
            state_next   = IDLE;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // tx is registered, so it is derived from where the FSM goes next
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit, legal range 2..65535.
REQ-002 Parameter: PARITY_EN, default 0, 1 inserts an even-parity bit after the data bits.
REQ-003 Port: clk  input  1  system clock, all state on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: tx_en  input  1  1 = permitted to start new frames.
REQ-006 Port: fifo_empty  input  1  upstream byte FIFO empty flag.
REQ-007 Port: fifo_rd_data  input  8  upstream FIFO read data, valid combinationally while fifo_rd=1 and fifo_empty=0.
REQ-008 Port: fifo_rd  output  1  single-cycle pop request to upstream FIFO.
REQ-009 Port: tx  output  1  serial line, idle high, registered.
REQ-010 Port: busy  output  1  1 from the pop cycle until the stop bit completes.
REQ-011 Port: frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-012 The block SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-013 In IDLE with tx_en=1 and fifo_empty=0, fifo_rd SHALL be 1 combinationally for exactly that cycle; fifo_rd SHALL be 0 in every other state and condition.
REQ-014 At the clock edge ending the pop cycle, fifo_rd_data SHALL be captured into an 8-bit shift register, the state SHALL go to START, and the bit-time counter SHALL clear.
REQ-015 tx SHALL be 0 for CLKS_PER_BIT cycles in START, beginning the cycle after the pop cycle.
REQ-016 In DATA, tx SHALL present the 8 captured bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit index counts 0..7.
REQ-017 In PARITY, tx SHALL equal the XOR of the 8 captured bits, held for CLKS_PER_BIT cycles.
REQ-018 In STOP, tx SHALL be 1 for CLKS_PER_BIT cycles; frame_done SHALL pulse in the final STOP cycle; the state SHALL then return to IDLE.
REQ-019 Frame length SHALL be exactly (10+PARITY_EN)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-020 Back-to-back frames: with data available, the next pop SHALL occur in the first IDLE cycle after STOP, giving exactly one idle-high cycle between frames.
REQ-021 tx_en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-022 fifo_empty and fifo_rd_data SHALL be ignored outside IDLE.
REQ-023 The bit-time counter SHALL be $clog2(CLKS_PER_BIT) bits wide and count 0..CLKS_PER_BIT-1, with no wrap beyond the terminal count.
REQ-024 busy SHALL be 1 in the pop cycle and in START/DATA/PARITY/STOP, and 0 otherwise.

Reset
REQ-025 While reset=0: state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, and all counters and the shift register = 0.
REQ-026 Reset asserted mid-frame SHALL drive tx high immediately, abandon the byte, and generate no pop until after release.
REQ-027 The first pop SHALL NOT occur earlier than the first rising edge after reset deassertion.

Structure
REQ-028 Package fifo_uart_pkg SHALL hold the state enumeration and the frame-length constants (DATA_BITS=8, STOP_BITS=1).
REQ-029 One sub-module, fifo_uart_baud_cnt (bit-time counter with clear input and terminal-count output), SHALL be instantiated; everything else stays in fifo_uart_tx.
REQ-030 The design SHALL connect directly to the 16x8 byte FIFO: FIFO rd to fifo_rd, rd_data to fifo_rd_data, empty to fifo_empty, with a shared clk/reset.

Verification (CLKS_PER_BIT=4)
REQ-031 Single byte 0xA5, PARITY_EN=0 -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; frame_done pulses at cycle 40 of the frame.
REQ-032 0xA5 with PARITY_EN=1 -> parity bit 0 and a 44-cycle frame; 0x07 -> parity bit 1.
REQ-033 FIFO holding 0x01 then 0x80 -> two frames separated by exactly 1 idle-high cycle; bytes arrive in order.
REQ-034 fifo_empty=1 for 100 cycles with tx_en=1 -> fifo_rd never asserts; tx=1 and busy=0 throughout.
REQ-035 tx_en dropped at DATA bit 3 with the FIFO non-empty -> current frame completes intact; no further pop until tx_en=1.
REQ-036 reset pulsed low at DATA bit 5 -> tx=1 and busy=0 within the same cycle; after release the next queued byte is transmitted in full.
